// File: rtl/rv32i_exec_slice_pkg.sv
// Shared constants and types for the RV32I execute/memory slice.
package rv32i_exec_slice_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MEM_DEPTH  = 256;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2,
    WB_SEC = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    SEC_AS_LUI   = 2'd0,
    SEC_AS_AUIPC = 2'd1,
    SEC_AS_JALR  = 2'd2,
    SEC_AS_NONE  = 2'd3
  } sec_src_e;

  // Arithmetic op from func3; alt selects SUB/SRA variants.
  function automatic alu_ctrl_e alu_op_from_func3(input logic [2:0] func3, input logic alt);
    alu_ctrl_e op;
    case (func3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_exec_slice_alu.sv
// 32-bit ALU with zero and last_bit flags used for branch resolution.
module rv32i_alu #(
  parameter int unsigned DATA_WIDTH = rv32i_exec_slice_pkg::DATA_WIDTH
) (
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  last_bit
);
  import rv32i_exec_slice_pkg::*;

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = src2[SHW-1:0];

  // Operation select.
  always_comb begin
    result = '0;
    case (alu_ctrl_e'(alu_ctrl))
      ALU_ADD:  result = src1 + src2;
      ALU_SUB:  result = src1 - src2;
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_XOR:  result = src1 ^ src2;
      ALU_SLL:  result = src1 << shamt;
      ALU_SRL:  result = src1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(src1) >>> shamt);
      ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (src1 < src2)};
      default:  result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign last_bit = result[0];

endmodule

// File: rtl/rv32i_exec_slice.sv
// Single-cycle RV32I execute/memory slice: control decode, ALU, data memory.
module rv32i_exec_slice #(
  parameter int unsigned DATA_WIDTH = rv32i_exec_slice_pkg::DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = rv32i_exec_slice_pkg::MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] immediate,
  input  logic                  init_done,
  input  logic [9:0]            init_w_addr,
  input  logic [DATA_WIDTH-1:0] init_w_dat,
  input  logic                  init_w_enb,
  input  logic [9:0]            debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data,
  output logic                  branch,
  output logic [2:0]            imm_src,
  output logic                  reg_write,
  output logic [1:0]            wrt_back_src,
  output logic [1:0]            second_add_src,
  output logic [DATA_WIDTH-1:0] alu_results,
  output logic [DATA_WIDTH-1:0] mem_rdata
);
  import rv32i_exec_slice_pkg::*;

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_b5;
  assign opcode   = instruction[6:0];
  assign func3    = instruction[14:12];
  assign func7_b5 = instruction[30];

  alu_ctrl_e alu_ctrl;
  imm_src_e  imm_src_d;
  wb_src_e   wb_d;
  sec_src_e  sec_d;
  logic      alu_src, rw_d, mem_read, mem_write, is_branch, is_jump, take;
  logic      zero, last_bit;
  logic [DATA_WIDTH-1:0] src2;

  // Main and ALU control decode from opcode/func3/func7.
  always_comb begin
    alu_ctrl  = ALU_ADD;
    alu_src   = 1'b0;
    imm_src_d = IMM_I;
    rw_d      = 1'b0;
    wb_d      = WB_ALU;
    sec_d     = SEC_AS_NONE;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    case (opcode)
      OP_R: begin
        alu_ctrl = alu_op_from_func3(func3, func7_b5);
        rw_d     = 1'b1;
      end
      OP_I: begin
        // func7[5] is part of the immediate except for SRAI.
        alu_ctrl = alu_op_from_func3(func3, func7_b5 && (func3 == 3'b101));
        alu_src  = 1'b1;
        rw_d     = 1'b1;
      end
      OP_LOAD: begin
        alu_src  = 1'b1;
        mem_read = 1'b1;
        rw_d     = 1'b1;
        wb_d     = WB_MEM;
      end
      OP_STORE: begin
        alu_src   = 1'b1;
        imm_src_d = IMM_S;
        mem_write = 1'b1;
      end
      OP_BRANCH: begin
        imm_src_d = IMM_B;
        sec_d     = SEC_AS_AUIPC;
        is_branch = 1'b1;
        case (func3)
          3'b000, 3'b001: alu_ctrl = ALU_SUB;
          3'b100, 3'b101: alu_ctrl = ALU_SLT;
          3'b110, 3'b111: alu_ctrl = ALU_SLTU;
          default:        is_branch = 1'b0;
        endcase
      end
      OP_JAL: begin
        alu_src   = 1'b1;
        imm_src_d = IMM_J;
        sec_d     = SEC_AS_AUIPC;
        rw_d      = 1'b1;
        wb_d      = WB_PC4;
        is_jump   = 1'b1;
      end
      OP_JALR: begin
        alu_src = 1'b1;
        sec_d   = SEC_AS_JALR;
        rw_d    = 1'b1;
        wb_d    = WB_PC4;
        is_jump = 1'b1;
      end
      OP_LUI: begin
        alu_src   = 1'b1;
        imm_src_d = IMM_U;
        sec_d     = SEC_AS_LUI;
        rw_d      = 1'b1;
        wb_d      = WB_SEC;
      end
      OP_AUIPC: begin
        alu_src   = 1'b1;
        imm_src_d = IMM_U;
        sec_d     = SEC_AS_AUIPC;
        rw_d      = 1'b1;
        wb_d      = WB_SEC;
      end
      default: ;
    endcase
  end

  assign src2 = alu_src ? immediate : rs2;

  rv32i_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .alu_ctrl (alu_ctrl),
    .src1     (rs1),
    .src2     (src2),
    .result   (alu_results),
    .zero     (zero),
    .last_bit (last_bit)
  );

  // Branch condition from ALU flags.
  always_comb begin
    take = 1'b0;
    case (func3)
      3'b000:         take = zero;
      3'b001:         take = !zero;
      3'b100, 3'b110: take = last_bit;
      3'b101, 3'b111: take = !last_bit;
      default:        take = 1'b0;
    endcase
  end

  // Control outputs, forced to safe values while in reset.
  always_comb begin
    if (rst) begin
      branch         = 1'b0;
      reg_write      = 1'b0;
      imm_src        = IMM_I;
      wrt_back_src   = WB_ALU;
      second_add_src = SEC_AS_NONE;
    end else begin
      branch         = is_jump || (is_branch && take);
      reg_write      = rw_d;
      imm_src        = imm_src_d;
      wrt_back_src   = wb_d;
      second_add_src = sec_d;
    end
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;

  assign mem_waddr = init_done ? alu_results[AW+1:2] : init_w_addr[AW+1:2];
  assign mem_wdata = init_done ? rs2 : init_w_dat;
  assign mem_we    = !rst && (init_done ? mem_write : init_w_enb);

  // Word write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign mem_rdata  = mem_read ? mem[alu_results[AW+1:2]] : '0;
  assign debug_data = mem[debug_addr[AW+1:2]];

  logic unused_bits;
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7],
                         alu_results[DATA_WIDTH-1:AW+2], alu_results[1:0],
                         init_w_addr[1:0], debug_addr[1:0]};

endmodule

// File: tb/tb_rv32i_exec_slice.sv
// Self-checking bench for rv32i_exec_slice: vector table, directed memory
// sequences and randomized ALU/memory traffic against a behavioural model.
module tb_rv32i_exec_slice;

  localparam logic [6:0] OPR = 7'h33, OPI = 7'h13, OPL = 7'h03, OPS = 7'h23, OPB = 7'h63;
  localparam logic [6:0] OPJAL = 7'h6F, OPJALR = 7'h67, OPLUI = 7'h37, OPAUI = 7'h17;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, rs1, rs2, immediate;
  logic        init_done;
  logic [9:0]  init_w_addr;
  logic [31:0] init_w_dat;
  logic        init_w_enb;
  logic [9:0]  debug_addr;
  logic [31:0] debug_data;
  logic        branch;
  logic [2:0]  imm_src;
  logic        reg_write;
  logic [1:0]  wrt_back_src;
  logic [1:0]  second_add_src;
  logic [31:0] alu_results;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  rv32i_exec_slice #(.DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .instruction    (instruction),
    .rs1            (rs1),
    .rs2            (rs2),
    .immediate      (immediate),
    .init_done      (init_done),
    .init_w_addr    (init_w_addr),
    .init_w_dat     (init_w_dat),
    .init_w_enb     (init_w_enb),
    .debug_addr     (debug_addr),
    .debug_data     (debug_data),
    .branch         (branch),
    .imm_src        (imm_src),
    .reg_write      (reg_write),
    .wrt_back_src   (wrt_back_src),
    .second_add_src (second_add_src),
    .alu_results    (alu_results),
    .mem_rdata      (mem_rdata)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [256];

  typedef struct packed {
    logic [31:0] instr, a, b, imm;
    logic        br, rw;
    logic [1:0]  wb, sec;
    logic [2:0]  isrc;
    logic [31:0] alu, mrd;
    logic [3:0]  care;  // [3] mrd, [2] imm_src, [1] wb, [0] alu
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 10'b0, f3, 5'b0, op};
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Architectural meaning of RV32I arithmetic ops.
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a * (32'd1 << sh);
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (!alt) return a / (32'd1 << sh);
        // floor division by 2^sh keeps the sign
        if (sa >= 0) return 32'(sa / (64'sd1 <<< sh));
        return 32'(-(((-sa) + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh)));
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    instruction = ins; rs1 = a; rs2 = b; immediate = imm;
  endtask

  initial begin
    logic [31:0] v, a, b, imm, exp, ins;
    logic [11:0] i12;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int unsigned idx;

    rst = 1'b1; init_done = 1'b0; init_w_enb = 1'b0; init_w_addr = '0; init_w_dat = '0;
    debug_addr = '0;
    drive(enc(7'h0, 3'd0, OPJAL), 32'd0, 32'd0, 32'd0);

    // Reset-state outputs
    repeat (2) @(negedge clk);
    #1;
    chk("rst.branch", {31'd0, branch}, 32'd0);
    chk("rst.reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst.wb", {30'd0, wrt_back_src}, 32'd1);
    chk("rst.sec", {30'd0, second_add_src}, 32'd3);
    chk("rst.imm_src", {29'd0, imm_src}, 32'd0);
    drive(enc(7'h0, 3'd2, OPL), 32'd0, 32'd0, 32'd4);
    #1;
    chk("rst.lw_reg_write", {31'd0, reg_write}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    drive(enc(7'h0, 3'd0, OPR), 32'd0, 32'd0, 32'd0);

    // Preload all words; first four are 5, 8, 0, 0
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      case (i)
        0: v = 32'd5;
        1: v = 32'd8;
        2, 3: v = 32'd0;
        default: v = $urandom;
      endcase
      init_w_addr = 10'(i * 4);
      init_w_dat  = v;
      init_w_enb  = 1'b1;
      mdl[i] = v;
    end
    @(negedge clk);
    init_w_enb = 1'b0;
    debug_addr = 10'h004; #1 chk("dbg@4", debug_data, 32'd8);
    debug_addr = 10'h00C; #1 chk("dbg@C", debug_data, 32'd0);

    // Decode/ALU vector table; no memory writes possible while init_done=0
    vecs.push_back('{enc(7'h00,3'd4,OPB), 32'd5, 32'd8, 32'd0, 1'b1,1'b0,2'd0,2'd1,3'd2, 32'd1, 32'd0, 4'b1101});
    vecs.push_back('{enc(7'h00,3'd4,OPB), 32'd8, 32'd5, 32'd0, 1'b0,1'b0,2'd0,2'd1,3'd2, 32'd0, 32'd0, 4'b1101});
    vecs.push_back('{enc(7'h20,3'd0,OPR), 32'd7, 32'd7, 32'd0, 1'b0,1'b1,2'd1,2'd3,3'd0, 32'd0, 32'd0, 4'b1011});
    vecs.push_back('{enc(7'h00,3'd0,OPB), 32'd7, 32'd7, 32'd0, 1'b1,1'b0,2'd0,2'd1,3'd2, 32'd0, 32'd0, 4'b1101});
    vecs.push_back('{enc(7'h00,3'd1,OPB), 32'd7, 32'd7, 32'd0, 1'b0,1'b0,2'd0,2'd1,3'd2, 32'd0, 32'd0, 4'b1101});
    vecs.push_back('{enc(7'h20,3'd5,OPR), 32'h80000000, 32'd4, 32'd0, 1'b0,1'b1,2'd1,2'd3,3'd0, 32'hF8000000, 32'd0, 4'b1011});
    vecs.push_back('{enc(7'h20,3'd5,OPI), 32'h80000000, 32'd0, 32'h404, 1'b0,1'b1,2'd1,2'd3,3'd0, 32'hF8000000, 32'd0, 4'b1111});
    vecs.push_back('{enc(7'h00,3'd6,OPB), 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0,1'b0,2'd0,2'd1,3'd2, 32'd0, 32'd0, 4'b1101});
    vecs.push_back('{enc(7'h00,3'd7,OPB), 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1,1'b0,2'd0,2'd1,3'd2, 32'd0, 32'd0, 4'b1101});
    vecs.push_back('{enc(7'h00,3'd5,OPB), 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0,1'b0,2'd0,2'd1,3'd2, 32'd1, 32'd0, 4'b1101});
    vecs.push_back('{enc(7'h00,3'd0,OPJAL), 32'd0, 32'd0, 32'd16, 1'b1,1'b1,2'd2,2'd1,3'd4, 32'd0, 32'd0, 4'b1110});
    vecs.push_back('{enc(7'h00,3'd0,OPJALR), 32'h100, 32'd0, 32'd4, 1'b1,1'b1,2'd2,2'd2,3'd0, 32'd0, 32'd0, 4'b1110});
    vecs.push_back('{enc(7'h00,3'd0,OPLUI), 32'd0, 32'd0, 32'h12345000, 1'b0,1'b1,2'd3,2'd0,3'd3, 32'd0, 32'd0, 4'b1110});
    vecs.push_back('{enc(7'h00,3'd0,OPAUI), 32'd0, 32'd0, 32'h12345000, 1'b0,1'b1,2'd3,2'd1,3'd3, 32'd0, 32'd0, 4'b1110});
    vecs.push_back('{enc(7'h00,3'd0,7'h7F), 32'd3, 32'd4, 32'd0, 1'b0,1'b0,2'd0,2'd3,3'd0, 32'd0, 32'd0, 4'b1000});
    vecs.push_back('{enc(7'h00,3'd2,OPS), 32'd0, 32'hA, 32'hC, 1'b0,1'b0,2'd0,2'd3,3'd1, 32'hC, 32'd0, 4'b1101});
    vecs.push_back('{enc(7'h00,3'd2,OPL), 32'd0, 32'd0, 32'd4, 1'b0,1'b1,2'd0,2'd3,3'd0, 32'd4, 32'd8, 4'b1111});
    vecs.push_back('{enc(7'h00,3'd2,OPL), 32'h404, 32'd0, 32'd0, 1'b0,1'b1,2'd0,2'd3,3'd0, 32'h404, 32'd8, 4'b1111});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].imm);
      #1;
      chk($sformatf("v%0d.branch", i), {31'd0, branch}, {31'd0, vecs[i].br});
      chk($sformatf("v%0d.reg_write", i), {31'd0, reg_write}, {31'd0, vecs[i].rw});
      chk($sformatf("v%0d.sec", i), {30'd0, second_add_src}, {30'd0, vecs[i].sec});
      if (vecs[i].care[0]) chk($sformatf("v%0d.alu", i), alu_results, vecs[i].alu);
      if (vecs[i].care[1]) chk($sformatf("v%0d.wb", i), {30'd0, wrt_back_src}, {30'd0, vecs[i].wb});
      if (vecs[i].care[2]) chk($sformatf("v%0d.imm_src", i), {29'd0, imm_src}, {29'd0, vecs[i].isrc});
      if (vecs[i].care[3]) chk($sformatf("v%0d.mem_rdata", i), mem_rdata, vecs[i].mrd);
    end

    // Datapath sw: old data before the edge, new data after
    @(negedge clk);
    init_done = 1'b1;
    drive(enc(7'h00, 3'd2, OPS), 32'd0, 32'hA, 32'hC);
    debug_addr = 10'h00C;
    #1 chk("sw.before", debug_data, 32'd0);
    @(posedge clk); #1;
    chk("sw.after", debug_data, 32'h0000000A);
    mdl[3] = 32'hA;

    // Reset suppresses a datapath store and the control enables
    @(negedge clk);
    rst = 1'b1;
    drive(enc(7'h00, 3'd2, OPS), 32'd0, 32'h55, 32'h8);
    debug_addr = 10'h008;
    #1;
    chk("rst_sw.branch", {31'd0, branch}, 32'd0);
    chk("rst_sw.reg_write", {31'd0, reg_write}, 32'd0);
    @(posedge clk); #1;
    chk("rst_sw.mem", debug_data, mdl[2]);

    // Reset also suppresses the preload port
    @(negedge clk);
    init_done = 1'b0; init_w_enb = 1'b1; init_w_addr = 10'h008; init_w_dat = 32'h77;
    @(posedge clk); #1;
    chk("rst_init.mem", debug_data, mdl[2]);

    // init_done=0: datapath store ignored
    @(negedge clk);
    rst = 1'b0; init_w_enb = 1'b0;
    drive(enc(7'h00, 3'd2, OPS), 32'd0, 32'h66, 32'h8);
    @(posedge clk); #1;
    chk("nodone_sw.mem", debug_data, mdl[2]);

    // init_done=1: preload port ignored
    @(negedge clk);
    init_done = 1'b1; init_w_enb = 1'b1; init_w_addr = 10'h010; init_w_dat = 32'hDEAD;
    drive(enc(7'h00, 3'd0, OPR), 32'd1, 32'd2, 32'd0);
    debug_addr = 10'h010;
    @(posedge clk); #1;
    chk("done_init.mem", debug_data, mdl[4]);

    // Address wrap-around and ignored byte offset on store
    @(negedge clk);
    init_w_enb = 1'b0;
    drive(enc(7'h00, 3'd2, OPS), 32'h1000, 32'h1234, 32'h17);
    debug_addr = 10'h014;
    @(posedge clk); #1;
    chk("wrap_sw.mem", debug_data, 32'h1234);
    mdl[5] = 32'h1234;

    // Preload write under a same-word lw: old data now, new after the edge
    @(negedge clk);
    init_done = 1'b0; init_w_enb = 1'b1; init_w_addr = 10'h018; init_w_dat = 32'hBEEF;
    drive(enc(7'h00, 3'd2, OPL), 32'd0, 32'd0, 32'h18);
    #1 chk("rdw.old", mem_rdata, mdl[6]);
    @(posedge clk); #1;
    chk("rdw.new", mem_rdata, 32'hBEEF);
    mdl[6] = 32'hBEEF;
    @(negedge clk);
    init_w_enb = 1'b0;

    // Randomized R/I-type arithmetic
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        drive(enc(f7, f3, OPR), a, b, $urandom);
        exp = ref_alu(f3, f7[5], a, b);
      end else begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          f7  = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          i12 = {f7, 5'($urandom_range(0, 31))};
        end else begin
          i12 = 12'($urandom_range(0, 4095));
        end
        imm = sext12(i12);
        ins = {i12, 5'd0, f3, 5'd0, OPI};
        drive(ins, a, b, imm);
        exp = ref_alu(f3, (f3 == 3'd5) && i12[10], a, imm);
      end
      #1;
      chk($sformatf("rnd_alu%0d f3=%0d", n, f3), alu_results, exp);
      chk($sformatf("rnd_alu%0d.rw", n), {31'd0, reg_write}, 32'd1);
    end

    // Randomized lw/sw traffic against the memory model
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      init_done = 1'b1;
      a   = $urandom;
      imm = sext12(12'($urandom_range(0, 4095)));
      b   = $urandom;
      idx = ((a + imm) / 4) % 256;
      if ($urandom_range(0, 1) == 0) begin
        drive(enc(7'h00, 3'd2, OPL), a, b, imm);
        #1;
        chk($sformatf("rnd_lw%0d.addr", n), alu_results, a + imm);
        chk($sformatf("rnd_lw%0d.data", n), mem_rdata, mdl[idx]);
      end else begin
        drive(enc(7'h00, 3'd2, OPS), a, b, imm);
        debug_addr = 10'(idx * 4);
        #1 chk($sformatf("rnd_sw%0d.old", n), debug_data, mdl[idx]);
        @(posedge clk); #1;
        mdl[idx] = b;
        chk($sformatf("rnd_sw%0d.new", n), debug_data, mdl[idx]);
      end
    end

    // Final full-memory sweep via the debug port
    @(negedge clk);
    drive(enc(7'h00, 3'd0, OPR), 32'd0, 32'd0, 32'd0);
    init_done = 1'b0;
    for (int i = 0; i < 256; i++) begin
      debug_addr = 10'(i * 4);
      #1 chk($sformatf("sweep[%0d]", i), debug_data, mdl[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
